// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: latches peripheral interrupt events as pending flags,
// gates them with a per-source mask and presents one registered INTR line
// plus the ID of the granted source to the CPU control unit.
// Optional build macro INTERRUPT_ARBITER_RR_EN selects round-robin priority;
// the default build uses fixed priority (lowest index wins).
module interrupt_arbiter #(
    parameter int N_SRC = 4,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] IRQ,
    input  logic             MASK_WE,
    input  logic [N_SRC-1:0] MASK_IN,
    input  logic             INT_ACK,
    input  logic             INT_DONE,
    output logic             INTR,
    output logic [ID_W-1:0]  SRC_ID,
    output logic [N_SRC-1:0] PENDING,
    output logic [N_SRC-1:0] MASK
);

    localparam int unsigned NS = N_SRC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_SERVICE
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] irq_edge;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] ack_clr;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    int unsigned      idx;

`ifdef INTERRUPT_ARBITER_RR_EN
    logic [ID_W-1:0]  rr_ptr;
`endif

    // Edge detection, arbitration candidates and the acknowledge clear mask
    always_comb begin
        irq_edge = IRQ & ~irq_q;
        req      = PENDING & MASK;
        ack_clr  = '0;
        if (state == ST_ASSERT && INT_ACK) begin
            ack_clr[SRC_ID] = 1'b1;
        end
    end

    // Priority search: scan from the start index upward, wrapping to 0
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NS; i++) begin
`ifdef INTERRUPT_ARBITER_RR_EN
            idx = 32'(rr_ptr) + i;
            if (idx >= NS) begin
                idx = idx - NS;
            end
`else
            idx = i;
`endif
            cand = ID_W'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Input edge register and mask register
    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_q <= '0;
            MASK  <= '0;
        end else begin
            irq_q <= IRQ;
            if (MASK_WE) begin
                MASK <= MASK_IN;
            end
        end
    end

    // Pending flags: a new edge on the bit being acknowledged keeps it set
    always_ff @(posedge CLK) begin
        if (RST) begin
            PENDING <= '0;
        end else begin
            PENDING <= (PENDING & ~ack_clr) | irq_edge;
        end
    end

    // Grant FSM with registered INTR / SRC_ID
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            INTR   <= 1'b0;
            SRC_ID <= '0;
`ifdef INTERRUPT_ARBITER_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        SRC_ID <= win_id;
                        INTR   <= 1'b1;
                        state  <= ST_ASSERT;
`ifdef INTERRUPT_ARBITER_RR_EN
                        rr_ptr <= (win_id == ID_W'(NS - 1)) ? '0 : win_id + 1'b1;
`endif
                    end
                end
                ST_ASSERT: begin
                    if (INT_ACK) begin
                        INTR  <= 1'b0;
                        state <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (INT_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    INTR  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: expected grant IDs are queued when a
// request is driven and popped when INTR is expected to rise.
module tb_interrupt_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] IRQ;
    logic       MASK_WE;
    logic [3:0] MASK_IN;
    logic       INT_ACK;
    logic       INT_DONE;
    logic       INTR;
    logic [1:0] SRC_ID;
    logic [3:0] PENDING;
    logic [3:0] MASK;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_seq[4];

    interrupt_arbiter #(.N_SRC(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IRQ      (IRQ),
        .MASK_WE  (MASK_WE),
        .MASK_IN  (MASK_IN),
        .INT_ACK  (INT_ACK),
        .INT_DONE (INT_DONE),
        .INTR     (INTR),
        .SRC_ID   (SRC_ID),
        .PENDING  (PENDING),
        .MASK     (MASK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag);
        int e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard required an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_intr"}, 32'(INTR), 32'd1);
            check({tag, "_id"}, 32'(SRC_ID), 32'(e));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_intr"}, 32'(INTR), 32'd0);
        check({tag, "_id"}, 32'(SRC_ID), 32'd0);
        check({tag, "_pend"}, 32'(PENDING), 32'd0);
        check({tag, "_mask"}, 32'(MASK), 32'd0);
    endtask

    task automatic ack_done();
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        INT_DONE = 1'b1;
        step();
        INT_DONE = 1'b0;
    endtask

    initial begin
`ifdef INTERRUPT_ARBITER_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        RST = 1'b1; IRQ = '0; MASK_WE = 1'b0; MASK_IN = '0;
        INT_ACK = 1'b0; INT_DONE = 1'b0;
        step();
        step();
        check_reset("reset");
        RST = 1'b0;

        // Reset and mask: single source, 2-cycle latency, ack clears pending
        MASK_WE = 1'b1; MASK_IN = 4'b1111;
        step();
        MASK_WE = 1'b0;
        check("mask_load", 32'(MASK), 32'hF);
        IRQ = 4'b0100;
        step();
        IRQ = '0;
        check("pend_src2", 32'(PENDING), 32'b0100);
        check("intr_not_yet", 32'(INTR), 32'd0);
        exp_q.push_back(2);
        step();
        check_grant("grant_src2");
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        check("ack_intr_low", 32'(INTR), 32'd0);
        check("ack_pend_clr", 32'(PENDING), 32'd0);
        INT_DONE = 1'b1;
        step();
        INT_DONE = 1'b0;
        step();
        check("idle_no_req", 32'(INTR), 32'd0);

        // Simultaneous requests: fixed priority picks 1 then 3
        IRQ = 4'b1010;
        step();
        IRQ = '0;
        exp_q.push_back(1);
        exp_q.push_back(3);
        step();
        check_grant("grant_pair_first");
        check("pair_pend", 32'(PENDING), 32'b1010);
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        check("pair_pend_after_ack", 32'(PENDING), 32'b1000);
        INT_DONE = 1'b1;
        step();
        INT_DONE = 1'b0;
        check("pair_idle_intr", 32'(INTR), 32'd0);
        step();
        check_grant("grant_pair_second");
        ack_done();
        check("pair_drained", 32'(PENDING), 32'd0);

        // Sources 0 and 1 continuously re-requested
        IRQ = 4'b0011;
        step();
        IRQ = '0;
        for (int g = 0; g < 4; g++) begin
            exp_q.push_back(exp_seq[g]);
            step();
            check_grant("rerequest_grant");
            INT_ACK = 1'b1;
            step();
            INT_ACK = 1'b0;
            IRQ = 4'(1 << exp_seq[g]);
            INT_DONE = 1'b1;
            step();
            IRQ = '0;
            INT_DONE = 1'b0;
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_reset("rst_after_rr");

        // Masking: pending is latched while masked, grant follows mask write
        IRQ = 4'b0001;
        step();
        IRQ = '0;
        check("masked_pend", 32'(PENDING), 32'b0001);
        step();
        step();
        check("masked_no_intr", 32'(INTR), 32'd0);
        MASK_WE = 1'b1; MASK_IN = 4'b0001;
        step();
        MASK_WE = 1'b0;
        check("mask_write_intr_low", 32'(INTR), 32'd0);
        exp_q.push_back(0);
        step();
        check_grant("grant_after_unmask");
        ack_done();
        MASK_WE = 1'b1; MASK_IN = 4'b1111;
        step();
        MASK_WE = 1'b0;

        // Set/clear collision on the acknowledged source
        IRQ = 4'b0010;
        step();
        IRQ = '0;
        exp_q.push_back(1);
        step();
        check_grant("collide_first");
        INT_ACK = 1'b1; IRQ = 4'b0010;
        step();
        INT_ACK = 1'b0; IRQ = '0;
        check("collide_pend_kept", 32'(PENDING), 32'b0010);
        check("collide_intr_low", 32'(INTR), 32'd0);
        INT_DONE = 1'b1;
        step();
        INT_DONE = 1'b0;
        exp_q.push_back(1);
        step();
        check_grant("collide_regrant");
        ack_done();

        // Reset while in ASSERT
        IRQ = 4'b0100;
        step();
        IRQ = '0;
        exp_q.push_back(2);
        step();
        check_grant("pre_rst_assert");
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_reset("rst_in_assert");
        MASK_WE = 1'b1; MASK_IN = 4'b0001; IRQ = 4'b0001;
        step();
        MASK_WE = 1'b0; IRQ = '0;
        exp_q.push_back(0);
        step();
        check_grant("grant_after_rst_assert");

        // Reset while in SERVICE, then a stray INT_DONE
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
        check("service_intr_low", 32'(INTR), 32'd0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_reset("rst_in_service");
        INT_DONE = 1'b1;
        step();
        INT_DONE = 1'b0;
        check("stray_done_intr", 32'(INTR), 32'd0);
        check("stray_done_pend", 32'(PENDING), 32'd0);
        MASK_WE = 1'b1; MASK_IN = 4'b1000; IRQ = 4'b1000;
        step();
        MASK_WE = 1'b0; IRQ = '0;
        exp_q.push_back(3);
        step();
        check_grant("grant_after_rst_service");
        ack_done();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
